// File: rtl/rv_ctrl_pkg.sv
// Shared control encodings for the multicycle RV32I sequencer: opcodes, FSM states,
// instruction classes and datapath mux selects.
package rv_ctrl_pkg;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    typedef enum logic [2:0] {
        StFetch   = 3'd0,
        StDecode  = 3'd1,
        StExecute = 3'd2,
        StMem     = 3'd3,
        StWb      = 3'd4,
        StTrap    = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        ClsNone,
        ClsR,
        ClsImm,
        ClsLoad,
        ClsStore,
        ClsBranch,
        ClsJal,
        ClsJalr,
        ClsLui,
        ClsAuipc
    } instr_class_e;

    typedef enum logic [1:0] {
        PcPlus4 = 2'd0,
        PcImm   = 2'd1,
        PcAlu   = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        WbAlu = 2'd0,
        WbMem = 2'd1,
        WbPc4 = 2'd2
    } wb_sel_e;

endpackage

// File: rtl/rv_opcode_decoder.sv
// Combinational opcode classifier; flags anything outside the supported RV32I base set.
module rv_opcode_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_e cls,
    output logic         legal
);

    always_comb begin
        cls   = ClsNone;
        legal = 1'b1;
        case (opcode)
            OpR:      cls = ClsR;
            OpImm:    cls = ClsImm;
            OpLoad:   cls = ClsLoad;
            OpStore:  cls = ClsStore;
            OpBranch: cls = ClsBranch;
            OpJal:    cls = ClsJal;
            OpJalr:   cls = ClsJalr;
            OpLui:    cls = ClsLui;
            OpAuipc:  cls = ClsAuipc;
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Control FSM for a multicycle RV32I core: FETCH/DECODE/EXECUTE/MEM/WB with a sticky TRAP.
// Strobes are decoded from the registered state, latched class and mem_ready.
module multicycle_sequencer
    import rv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       alu_b_sel,
    output logic       illegal_instr,
    output logic [2:0] state_o
);

    state_e       state_q;
    instr_class_e cls_q;
    instr_class_e dec_cls;
    logic         dec_legal;

    rv_opcode_decoder u_decoder (
        .opcode (opcode),
        .cls    (dec_cls),
        .legal  (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StFetch;
            cls_q   <= ClsNone;
        end else begin
            case (state_q)
                StFetch: if (mem_ready) state_q <= StDecode;
                StDecode: begin
                    cls_q   <= dec_cls;
                    state_q <= dec_legal ? StExecute : StTrap;
                end
                StExecute: begin
                    if (cls_q == ClsBranch) begin
                        state_q <= StFetch;
                    end else if (cls_q == ClsLoad || cls_q == ClsStore) begin
                        state_q <= StMem;
                    end else begin
                        state_q <= StWb;
                    end
                end
                StMem: begin
                    if (mem_ready) state_q <= (cls_q == ClsStore) ? StFetch : StWb;
                end
                StWb:    state_q <= StFetch;
                StTrap:  state_q <= StTrap;
                default: state_q <= StTrap;
            endcase
        end
    end

    // Everything is forced low while rst_n is held, so a pending request drops at once.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PcPlus4;
        reg_write     = 1'b0;
        wb_sel        = WbAlu;
        alu_b_sel     = 1'b0;
        illegal_instr = 1'b0;
        state_o       = '0;
        if (rst_n) begin
            state_o = state_q;
            case (state_q)
                StFetch: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                end
                StExecute: begin
                    alu_b_sel = (cls_q == ClsR) || (cls_q == ClsBranch);
                    if (cls_q == ClsBranch) begin
                        pc_write = 1'b1;
                        pc_src   = branch_taken ? PcImm : PcPlus4;
                    end
                end
                StMem: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (cls_q == ClsStore);
                    pc_write     = (cls_q == ClsStore) && mem_ready;
                end
                StWb: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    case (cls_q)
                        ClsLoad: wb_sel = WbMem;
                        ClsJal: begin
                            wb_sel = WbPc4;
                            pc_src = PcImm;
                        end
                        ClsJalr: begin
                            wb_sel = WbPc4;
                            pc_src = PcAlu;
                        end
                        default: ;
                    endcase
                end
                StTrap:  illegal_instr = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed cycle-by-cycle bench for multicycle_sequencer; each output vector is hand-derived.
module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_req, mem_we, mem_addr_sel, ir_write, pc_write, reg_write;
    logic       alu_b_sel, illegal_instr;
    logic [1:0] pc_src, wb_sel;
    logic [2:0] state_o;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    multicycle_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .branch_taken  (branch_taken),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr_sel  (mem_addr_sel),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .reg_write     (reg_write),
        .wb_sel        (wb_sel),
        .alu_b_sel     (alu_b_sel),
        .illegal_instr (illegal_instr),
        .state_o       (state_o)
    );

    // {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, reg_write, wb_sel,
    //  alu_b_sel, illegal_instr, state}
    logic [14:0] outs;
    assign outs = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, reg_write,
                   wb_sel, alu_b_sel, illegal_instr, state_o};

    function automatic logic [14:0] e(input bit mr, input bit we, input bit as, input bit irw,
                                      input bit pcw, input int pcs, input bit rw, input int wbs,
                                      input bit ab, input bit ill, input int st);
        return {mr, we, as, irw, pcw, pcs[1:0], rw, wbs[1:0], ab, ill, st[2:0]};
    endfunction

    logic [14:0] zero, f0, f1, dc, er, ei, ebt, ebn, ml, msw, msr, wa, wl, wjr, tr;

    task automatic test_reset();
        rst_n = 1'b0; opcode = 7'h00; branch_taken = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (outs !== zero) $display("FAIL reset cyc%0d got %h want %h", i, outs, zero);
            else passed++;
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
    endtask

    // ADD with mem_ready held high throughout, opcode corrupted after DECODE.
    task automatic test_add();
        logic [14:0] ev[$] = '{f1, dc, er, wa, f0};
        bit          rd[$] = '{1, 1, 1, 1, 0};
        opcode = 7'b0110011;
        for (int i = 0; i < ev.size(); i++) begin
            mem_ready = rd[i];
            if (i == 2) opcode = 7'b1111111;
            @(negedge clk);
            total++;
            if (outs !== ev[i]) $display("FAIL add cyc%0d got %h want %h", i, outs, ev[i]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_wait();
        logic [14:0] ev[$] = '{f1, dc, ei, ml, ml, ml, wl, f0};
        bit          rd[$] = '{1, 0, 0, 0, 0, 1, 0, 0};
        opcode = 7'b0000011;
        for (int i = 0; i < ev.size(); i++) begin
            mem_ready = rd[i];
            @(negedge clk);
            total++;
            if (outs !== ev[i]) $display("FAIL load cyc%0d got %h want %h", i, outs, ev[i]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch(input bit taken);
        logic [14:0] ev[$];
        bit          rd[$] = '{1, 0, 0, 0};
        ev = '{f1, dc, taken ? ebt : ebn, f0};
        opcode = 7'b1100011;
        branch_taken = taken;
        for (int i = 0; i < ev.size(); i++) begin
            mem_ready = rd[i];
            @(negedge clk);
            total++;
            if (outs !== ev[i])
                $display("FAIL branch%0d cyc%0d got %h want %h", taken, i, outs, ev[i]);
            else passed++;
            @(posedge clk); #1;
        end
        branch_taken = 1'b0;
    endtask

    task automatic test_jalr();
        logic [14:0] ev[$] = '{f1, dc, ei, wjr, f0};
        bit          rd[$] = '{1, 0, 0, 0, 0};
        opcode = 7'b1100111;
        for (int i = 0; i < ev.size(); i++) begin
            mem_ready = rd[i];
            @(negedge clk);
            total++;
            if (outs !== ev[i]) $display("FAIL jalr cyc%0d got %h want %h", i, outs, ev[i]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    // Store with one fetch wait state and a zero-wait memory phase.
    task automatic test_store();
        logic [14:0] ev[$] = '{f0, f1, dc, ei, msr, f0};
        bit          rd[$] = '{0, 1, 0, 0, 1, 0};
        opcode = 7'b0100011;
        for (int i = 0; i < ev.size(); i++) begin
            mem_ready = rd[i];
            @(negedge clk);
            total++;
            if (outs !== ev[i]) $display("FAIL store cyc%0d got %h want %h", i, outs, ev[i]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_trap();
        logic [14:0] ev[$];
        bit          rd[$];
        bit          rs[$];
        ev = '{f1, dc}; rd = '{1, 0}; rs = '{1, 1};
        for (int k = 0; k < 10; k++) begin
            ev.push_back(tr); rd.push_back(k[0]); rs.push_back(1'b1);
        end
        ev.push_back(zero); rd.push_back(1'b0); rs.push_back(1'b0);
        ev.push_back(f0);   rd.push_back(1'b0); rs.push_back(1'b1);
        opcode = 7'b1111111;
        for (int i = 0; i < ev.size(); i++) begin
            mem_ready = rd[i];
            rst_n = rs[i];
            @(negedge clk);
            total++;
            if (outs !== ev[i]) $display("FAIL trap cyc%0d got %h want %h", i, outs, ev[i]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    // Reset lands while a store waits in MEM; the store must not retire.
    task automatic test_store_reset();
        logic [14:0] ev[$] = '{f1, dc, ei, msw, msw, zero, f0, f0, f1, dc};
        bit          rd[$] = '{1, 0, 0, 0, 0, 1, 0, 0, 1, 0};
        bit          rs[$] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
        opcode = 7'b0100011;
        for (int i = 0; i < ev.size(); i++) begin
            mem_ready = rd[i];
            rst_n = rs[i];
            @(negedge clk);
            total++;
            if (outs !== ev[i]) $display("FAIL swrst cyc%0d got %h want %h", i, outs, ev[i]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        zero = '0;
        f0  = e(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        f1  = e(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        dc  = e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        er  = e(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2);
        ei  = e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        ebt = e(0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 2);
        ebn = e(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 2);
        ml  = e(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3);
        msw = e(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3);
        msr = e(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 3);
        wa  = e(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 4);
        wl  = e(0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 4);
        wjr = e(0, 0, 0, 0, 1, 2, 1, 2, 0, 0, 4);
        tr  = e(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5);

        test_reset();
        test_add();
        test_load_wait();
        test_branch(1'b1);
        test_branch(1'b0);
        test_jalr();
        test_store();
        test_trap();
        test_store_reset();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk (rising edge) and rst_n.
REQ-002 clk  input  1  core clock, all state on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 opcode  input  7  instruction[6:0] from instruction register, valid from DECODE onward.
REQ-005 branch_taken  input  1  ALU compare result, valid in EXECUTE.
REQ-006 mem_ready  input  1  single-port memory completion strobe, one cycle.
REQ-007 mem_req  output  1  memory access request.
REQ-008 mem_we  output  1  store write enable, qualifies mem_req.
REQ-009 mem_addr_sel  output  1  0 = PC, 1 = ALU result.
REQ-010 ir_write  output  1  instruction register load strobe.
REQ-011 pc_write  output  1  PC update strobe.
REQ-012 pc_src  output  2  0 = PC+4, 1 = PC+imm (branch/JAL), 2 = ALU (JALR, low bit cleared downstream).
REQ-013 reg_write  output  1  register file write strobe.
REQ-014 wb_sel  output  2  0 = ALU, 1 = memory data, 2 = PC+4.
REQ-015 alu_b_sel  output  1  1 = rs2, 0 = immediate.
REQ-016 illegal_instr  output  1  sticky trap flag.
REQ-017 state_o  output  3  current state encoding, debug.

Function
REQ-018 States SHALL be FETCH, DECODE, EXECUTE, MEM, WB, TRAP; outputs are decoded from registered state plus mem_ready only.
REQ-019 FETCH: mem_req=1, mem_we=0, mem_addr_sel=0, held until mem_ready; on the mem_ready cycle ir_write=1, next = DECODE.
REQ-020 DECODE: one cycle; opcode class SHALL be latched into a class register; supported opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111; any other opcode -> TRAP.
REQ-021 EXECUTE: one cycle; alu_b_sel=1 for R-type and BRANCH, else 0.
REQ-022 EXECUTE exit: BRANCH -> pc_write=1, pc_src = branch_taken ? 1 : 0, next FETCH; LOAD/STORE -> MEM; all others -> WB.
REQ-023 MEM: mem_req=1, mem_addr_sel=1, mem_we=1 only for STORE; held until mem_ready; STORE then pc_write=1, pc_src=0, next FETCH; LOAD next WB.
REQ-024 WB: one cycle, reg_write=1, pc_write=1; wb_sel = 1 for LOAD, 2 for JAL/JALR, else 0; pc_src = 1 for JAL, 2 for JALR, else 0; next FETCH.
REQ-025 Latency with zero-wait memory (mem_ready in first request cycle): branch 3, store 4, R/I/LUI/AUIPC/JAL/JALR 4, load 5 cycles; each wait cycle adds one.
REQ-026 mem_req, mem_we, mem_addr_sel SHALL stay stable from assertion until the mem_ready cycle inclusive.
REQ-027 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-028 Opcode changes after DECODE SHALL not affect sequencing (latched class governs).
REQ-029 At most one of ir_write, reg_write asserted in any cycle; pc_write at most once per instruction.
REQ-030 TRAP: illegal_instr=1, all strobes and mem_req 0, remain until reset.

Reset
REQ-031 rst_n low at a rising edge SHALL force state FETCH, class register clear, illegal_instr 0, in any state including mid-handshake.
REQ-032 While rst_n low, all outputs SHALL be 0 (mem_req dropped immediately); first fetch request on the first cycle after rst_n returns high.

Structure
REQ-033 Opcode constants, state enum, pc_src and wb_sel encodings SHALL reside in shared package rv_ctrl_pkg.
REQ-034 Opcode-to-class decoding SHALL be a combinational sub-module rv_opcode_decoder (outputs class, legal).

Verification
REQ-035 ADD 0110011, mem_ready on first request -> FETCH,DECODE,EXECUTE,WB; reg_write=1 wb_sel=0 in cycle 4, pc_src=0.
REQ-036 LW 0000011, 2 wait cycles in MEM -> mem_req/mem_addr_sel=1 held 3 cycles, then WB with wb_sel=1; total 7 cycles.
REQ-037 BEQ 1100011, branch_taken=1 -> pc_write=1 pc_src=1 in EXECUTE, reg_write never 1; with branch_taken=0 -> pc_src=0.
REQ-038 JALR 1100111 -> WB with reg_write=1, wb_sel=2, pc_src=2.
REQ-039 Opcode 1111111 -> TRAP, illegal_instr=1 persisting 10 cycles with mem_req=0; rst_n low one cycle -> FETCH, illegal_instr=0.
REQ-040 SW 0100011 with rst_n low during MEM wait -> mem_req 0 during reset, FETCH with mem_addr_sel=0 after release, no pc_write.
